// File: rtl/vga_mem_arbiter.sv
// vga_mem_arbiter: shares one memory port between VGA reads (priority) and CPU reads/writes (starvation-forced slot), with tagged read return; ports: vga_*/cpu_* requesters, mem_* memory port
module vga_mem_arbiter #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int RD_LATENCY     = 1,
  parameter int CPU_STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  logic [3:0]            starve_q, starve_d;
  logic [RD_LATENCY-1:0] vld_q, vld_d, own_q, own_d;
  logic                  force_cpu;
  always_comb begin
    force_cpu  = cpu_req && starve_q == 4'(CPU_STARVE_MAX);
    vga_gnt    = !reset && vga_req && !force_cpu;
    cpu_gnt    = !reset && cpu_req && (force_cpu || !vga_req);
    mem_en     = vga_gnt | cpu_gnt;
    mem_we     = cpu_gnt & cpu_we;
    mem_addr   = cpu_gnt ? cpu_addr : vga_gnt ? vga_addr : '0;
    mem_wdata  = cpu_gnt ? cpu_wdata : '0;
    starve_d   = (cpu_gnt || !cpu_req) ? 4'd0 :
                 starve_q == 4'(CPU_STARVE_MAX) ? starve_q : starve_q + 4'd1;
    vld_d      = RD_LATENCY'({vld_q, vga_gnt | (cpu_gnt & !cpu_we)});
    own_d      = RD_LATENCY'({own_q, cpu_gnt});
    vga_rvalid = !reset && vld_q[RD_LATENCY-1] && !own_q[RD_LATENCY-1];
    cpu_rvalid = !reset && vld_q[RD_LATENCY-1] && own_q[RD_LATENCY-1];
    vga_rdata  = vga_rvalid ? mem_rdata : '0;
    cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
      vld_q    <= '0;
      own_q    <= '0;
    end else begin
      starve_q <= starve_d;
      vld_q    <= vld_d;
      own_q    <= own_d;
    end
  end
endmodule

// File: tb/tb_vga_mem_arbiter.sv
// tb_vga_mem_arbiter: table-driven check of grants, memory port and tagged read return against a RAM model
module tb_vga_mem_arbiter;
  localparam int LAT = 2;
  localparam int MAX = 4;
  logic        clk = 0, reset = 1;
  logic        vga_req = 0, cpu_req = 0, cpu_we = 0;
  logic [15:0] vga_addr = 0, cpu_addr = 0, cpu_wdata = 0;
  logic        vga_gnt, vga_rvalid, cpu_gnt, cpu_rvalid, mem_en, mem_we;
  logic [15:0] vga_rdata, cpu_rdata, mem_addr, mem_wdata, mem_rdata;
  vga_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LATENCY(LAT), .CPU_STARVE_MAX(MAX)) dut (
    .clk(clk), .reset(reset),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
    .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  logic [15:0] ram [65536];
  logic [15:0] ref_ram [65536];
  logic [15:0] rp [LAT];
  always @(posedge clk) begin
    if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    rp[0] <= ram[mem_addr];
    for (int i = 1; i < LAT; i++) rp[i] <= rp[i-1];
  end
  assign mem_rdata = rp[LAT-1];
  typedef struct {
    logic        rst, vr;
    logic [15:0] va;
    logic        cr, cw;
    logic [15:0] ca, cd;
    logic        ev, ec;
  } vec_t;
  typedef struct {
    logic        own;
    logic [15:0] d;
    int          due;
  } rsp_t;
  vec_t tbl[$];
  rsp_t sb[$];
  int   cyc = 0, n_vec = 0, n_bad = 0;
  function automatic vec_t mk(input logic rst, vr, input logic [15:0] va, input logic cr, cw,
                              input logic [15:0] ca, cd, input logic ev, ec);
    vec_t v;
    v.rst = rst; v.vr = vr; v.va = va; v.cr = cr; v.cw = cw;
    v.ca = ca; v.cd = cd; v.ev = ev; v.ec = ec;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [15:0] a, input logic [15:0] e);
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, a, e);
    end
  endtask
  task automatic apply(input vec_t v);
    logic [15:0] ea, ed;
    logic        hit;
    rsp_t        r, nr;
    @(negedge clk);
    reset = v.rst; vga_req = v.vr; vga_addr = v.va;
    cpu_req = v.cr; cpu_we = v.cw; cpu_addr = v.ca; cpu_wdata = v.cd;
    if (v.rst) sb.delete();
    #1;
    ea = v.ev ? v.va : v.ec ? v.ca : 16'h0;
    ed = v.ec ? v.cd : 16'h0;
    chk("vga_gnt", {15'b0, vga_gnt}, {15'b0, v.ev});
    chk("cpu_gnt", {15'b0, cpu_gnt}, {15'b0, v.ec});
    chk("mem_en", {15'b0, mem_en}, {15'b0, v.ev | v.ec});
    chk("mem_we", {15'b0, mem_we}, {15'b0, v.ec & v.cw});
    chk("mem_addr", mem_addr, ea);
    chk("mem_wdata", mem_wdata, ed);
    if (sb.size() > 0 && sb[0].due == cyc) begin
      hit = 1;
      r = sb.pop_front();
    end else begin
      hit = 0;
      r.own = 0; r.d = 0; r.due = 0;
    end
    chk("vga_rvalid", {15'b0, vga_rvalid}, {15'b0, hit & !r.own});
    chk("cpu_rvalid", {15'b0, cpu_rvalid}, {15'b0, hit & r.own});
    chk("vga_rdata", vga_rdata, (hit && !r.own) ? r.d : 16'h0);
    chk("cpu_rdata", cpu_rdata, (hit && r.own) ? r.d : 16'h0);
    if (v.ev || (v.ec && !v.cw)) begin
      nr.own = v.ec; nr.d = ref_ram[ea]; nr.due = cyc + LAT;
      sb.push_back(nr);
    end
    if (v.ec && v.cw) ref_ram[v.ca] = v.cd;
    cyc++;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask
  initial begin
    int g;
    for (int i = 0; i < 65536; i++) begin
      ram[i] = 16'(i) ^ 16'h5A5A;
      ref_ram[i] = 16'(i) ^ 16'h5A5A;
    end
    ram[16'h0010] = 16'hBEEF;
    ref_ram[16'h0010] = 16'hBEEF;
    tbl.push_back(mk(1, 1, 16'hF000, 1, 0, 16'h0010, 0, 0, 0));
    tbl.push_back(mk(1, 1, 16'hF000, 1, 1, 16'h0010, 16'h1234, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 16'h0010, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 16'hF001, 16'h4142, 0, 1));
    tbl.push_back(mk(0, 1, 16'hF001, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 16'hF000, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 16'hF001, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 16'h0002, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 16'hF003, 1, 0, 16'h0004, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 16'h0004, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 16'hF000, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 1, 16'hF005, 1, 0, 16'h0006, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 16'hF002, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (tbl[i]) apply(tbl[i]);
    g = 0;
    for (int i = 0; i < 3 * (MAX + 1); i++) begin
      logic ec;
      ec = (i % (MAX + 1)) == MAX;
      apply(mk(0, 1, 16'hF010 + 16'(g), 1, 0, 16'h0020 + 16'(i), 0, !ec, ec));
      if (!ec) g++;
    end
    idle(LAT + 1);
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d responses never arrived, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
